// File: rtl/shift32_sequencer.sv
// shift32_sequencer: round-robin two-client 32-bit shift/rotate built on one shared 16-bit rotator
module shift_rotator (
   input  logic [15:0] i_src,
   input  logic [3:0]  i_amt,
   input  logic        i_rot,
   output logic [15:0] o_y
);
   assign o_y = (i_src << i_amt) | ({16{i_rot}} & (i_src >> (5'd16 - {1'b0, i_amt})));
endmodule

module shift32_sequencer #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [31:0] data0,
   input  logic [4:0]  amt0,
   input  logic        rot0,
   input  logic        req1,
   input  logic [31:0] data1,
   input  logic [4:0]  amt1,
   input  logic        rot1,
   output logic        busy,
   output logic [31:0] res,
   output logic        done,
   output logic        done_id
);
   typedef enum logic [1:0] {IDLE, PASS_LO, PASS_HI, DONE} state_t;
   state_t r_state, w_next;
   logic        r_ptr, r_id, r_a4, r_rot;
   logic [3:0]  r_s;
   logic [15:0] r_hi, r_lo, r_rl;
   logic [31:0] r_res;
   logic        w_any, w_g1;
   logic [31:0] w_d;
   logic [4:0]  w_a;
   logic [15:0] w_src, w_y, w_m, w_res_hi, w_res_lo;
   assign w_any = req0 | req1;
   assign w_g1  = req1 & (~req0 | r_ptr);
   assign w_d   = w_g1 ? data1 : data0;
   assign w_a   = w_g1 ? amt1 : amt0;
   assign w_src = (r_state == PASS_HI) ? r_hi : r_lo;
   assign w_m   = (16'h1 << r_s) - 16'h1;
   shift_rotator u_rot (.i_src(w_src), .i_amt(r_s), .i_rot(1'b1), .o_y(w_y));
   // In PASS_HI the rotator output is rH; logical shifts >=16 take the original low half from rH
   assign w_res_hi = (!r_rot && r_a4) ? (w_y & ~w_m) : ((w_y & ~w_m) | (r_rl & w_m));
   assign w_res_lo = r_rot ? ((r_rl & ~w_m) | (w_y & w_m)) : (r_a4 ? 16'h0 : (r_rl & ~w_m));
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE)    ? (w_any ? PASS_LO : IDLE) :
               (r_state == PASS_LO) ? PASS_HI :
               (r_state == PASS_HI) ? DONE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= RR_INIT;
         r_id  <= 1'b0;
         r_a4  <= 1'b0;
         r_rot <= 1'b0;
         r_s   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_rl  <= '0;
         r_res <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_ptr <= ~w_g1;
            r_id  <= w_g1;
            r_a4  <= w_a[4];
            r_rot <= w_g1 ? rot1 : rot0;
            r_s   <= w_a[3:0];
            r_hi  <= w_a[4] ? w_d[15:0]  : w_d[31:16];
            r_lo  <= w_a[4] ? w_d[31:16] : w_d[15:0];
         end
         if (r_state == PASS_LO) r_rl <= w_y;
         if (r_state == PASS_HI) r_res <= {w_res_hi, w_res_lo};
      end
   end
   assign busy    = r_state != IDLE;
   assign done    = r_state == DONE;
   assign done_id = done & r_id;
   assign res     = r_res;
endmodule

// File: tb/tb_shift32_sequencer.sv
// tb_shift32_sequencer: directed checks of latency, arbitration, reset abort and all amt/rot combinations
module tb_shift32_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, rot0 = 1'b0, req1 = 1'b0, rot1 = 1'b0;
   logic [31:0] data0 = '0, data1 = '0;
   logic [4:0]  amt0 = '0, amt1 = '0;
   logic        busy, done, done_id;
   logic [31:0] res;
   int          errors = 0;
   int          checks = 0;
   int          n;

   shift32_sequencer #(.RR_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .amt0(amt0), .rot0(rot0),
      .req1(req1), .data1(data1), .amt1(amt1), .rot1(rot1),
      .busy(busy), .res(res), .done(done), .done_id(done_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] a, input logic r);
      logic [63:0] t;
      t = {d, d} << a;
      return r ? t[63:32] : (d << a);
   endfunction

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 12);
   endtask

   task automatic op(input logic id, input logic [31:0] d, input logic [4:0] a, input logic r,
                     input logic [31:0] exp, input string tag);
      int c;
      if (id) begin req1 = 1'b1; data1 = d; amt1 = a; rot1 = r; end
      else    begin req0 = 1'b1; data0 = d; amt0 = a; rot0 = r; end
      @(negedge clk);
      c = 1;
      chk({tag, " busy_after_grant"}, 32'(busy), 32'd1);
      while (!done && c < 12) begin
         @(negedge clk);
         c++;
      end
      chk({tag, " latency"}, 32'(c), 32'd3);
      chk({tag, " done_id"}, 32'(done_id), 32'(id));
      chk({tag, " res"}, res, exp);
      if (id) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " idle_after"}, 32'(busy), 32'd0);
      chk({tag, " res_held"}, res, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset done_id", 32'(done_id), 32'd0);
      chk("reset res", res, 32'h0);

      op(1'b0, 32'h1234_5678, 5'd4,  1'b1, 32'h2345_6781, "rot4");
      op(1'b0, 32'h1234_5678, 5'd4,  1'b0, 32'h2345_6780, "shl4");
      op(1'b0, 32'h1234_5678, 5'd20, 1'b0, 32'h6780_0000, "shl20");
      op(1'b0, 32'h1234_5678, 5'd20, 1'b1, 32'h6781_2345, "rot20");
      op(1'b0, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, "rot0");
      op(1'b1, 32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, "shl0");
      op(1'b1, 32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234, "rot16");
      op(1'b1, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, "shl31");

      // tie: pointer is 0 here, so req0 wins and req1 follows
      req0 = 1'b1; data0 = 32'hDEAD_BEEF; amt0 = 5'd8; rot0 = 1'b1;
      req1 = 1'b1; data1 = 32'h0F0F_00FF; amt1 = 5'd12; rot1 = 1'b0;
      wait_done(n);
      chk("tie1 first latency", 32'(n), 32'd3);
      chk("tie1 first id", 32'(done_id), 32'd0);
      chk("tie1 first res", res, 32'hADBE_EFDE);
      req0 = 1'b0;
      wait_done(n);
      chk("tie1 second latency", 32'(n), 32'd4);
      chk("tie1 second id", 32'(done_id), 32'd1);
      chk("tie1 second res", res, 32'hF00F_F000);
      req1 = 1'b0;
      @(negedge clk);
      op(1'b0, 32'h8000_0001, 5'd1, 1'b1, 32'h0000_0003, "solo0");
      // pointer now favours req1
      req0 = 1'b1; data0 = 32'h0000_FFFF; amt0 = 5'd4; rot0 = 1'b0;
      req1 = 1'b1; data1 = 32'hF000_000F; amt1 = 5'd4; rot1 = 1'b1;
      wait_done(n);
      chk("tie2 first id", 32'(done_id), 32'd1);
      chk("tie2 first res", res, 32'h0000_00FF);
      req1 = 1'b0;
      wait_done(n);
      chk("tie2 second id", 32'(done_id), 32'd0);
      chk("tie2 second res", res, 32'h000F_FFF0);
      req0 = 1'b0;
      @(negedge clk);

      // reset while in PASS_HI abandons the operation
      req0 = 1'b1; data0 = 32'hCAFE_F00D; amt0 = 5'd3; rot0 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1; req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort res", res, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort no_done", 32'(done), 32'd0);
      end
      op(1'b0, 32'hCAFE_F00D, 5'd3, 1'b1, 32'h57F7_806E, "after_abort");

      for (int i = 0; i < 64; i++) begin
         logic [31:0] d;
         d = $urandom;
         op(i[0], d, i[5:1], i[0], ref_model(d, i[5:1], i[0]), $sformatf("sweep a=%0d r=%0d", i[5:1], i[0]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
